// File: rtl/uart_packet_tx.sv
// ---------------------------------------------------------------------------
// uart_packet_tx
//
// Packet-framed UART transmitter. A host appends bytes into an internal
// buffer and then commits the packet. The block sends the bytes as 8N1
// frames with no idle time between frames. It then holds the line high for
// a guaranteed idle gap, so a receiver can find end-of-packet by detecting
// an idle period.
//
// Parameters:
//   CLOCK_FREQUENCY  system clock in Hz
//   BAUD_RATE        line rate in bit/s (cycles per bit = CLOCK_FREQUENCY / BAUD_RATE)
//   MAX_LEN          buffer depth in bytes (power of two, 2..256)
//   GAP_BYTES        post-packet idle gap in byte periods (minimum 1)
//
// Optional feature macro: UART_PKT_CHECKSUM_EN
//   When defined, one extra frame follows the payload. It carries the two's
//   complement of the 8-bit payload sum, so payload plus checksum adds to
//   0x00 mod 256. When undefined, no accumulator logic is built.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high reset
//   uart_tx_pin   serial line, idle high (registered)
//   pkt_data_in   byte to append to the packet buffer
//   pkt_write_en  append strobe, one byte per cycle
//   pkt_commit    start transmitting the loaded packet
//   busy          high from commit acceptance until the end of the gap
//   buffer_full   buffer holds MAX_LEN bytes
//   byte_count    number of bytes currently loaded
//   overflow      sticky flag: a write was dropped (cleared at pkt_sent)
//   pkt_sent      one-cycle pulse on the final cycle of the idle gap
// ---------------------------------------------------------------------------
module uart_packet_tx #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int MAX_LEN         = 32,
  parameter int GAP_BYTES       = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      uart_tx_pin,
  input  logic [7:0]                pkt_data_in,
  input  logic                      pkt_write_en,
  input  logic                      pkt_commit,
  output logic                      busy,
  output logic                      buffer_full,
  output logic [$clog2(MAX_LEN):0]  byte_count,
  output logic                      overflow,
  output logic                      pkt_sent
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = $clog2(MAX_LEN) + 1;
  localparam int IDX_W        = $clog2(MAX_LEN);
  localparam int BAUD_W       = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int GAP_CYCLES   = GAP_BYTES * 10 * BAUD_DIVISOR;
  localparam int GAP_W        = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic              tx_reg;
  logic              tx_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_idx;
  logic [IDX_W-1:0]  byte_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        buffer [MAX_LEN];

  logic              write_ok;
  logic              write_drop;
  logic [CNT_W-1:0]  count_after;
  logic              commit_ok;
  logic              baud_tick;
  logic              last_payload;
  logic              last_frame;
  logic              gap_end;
  logic [7:0]        cur_byte;

  // Writes only land in IDLE with room left. Every other write is dropped
  // and flagged, including writes that arrive while a packet is in flight.
  assign write_ok    = pkt_write_en && (state == IDLE) && !buffer_full;
  assign write_drop  = pkt_write_en && !write_ok;

  // A commit in the same cycle as an accepted write sees the byte that
  // write adds, so a write-plus-commit on an empty buffer sends one byte.
  assign count_after = byte_count + {{(CNT_W-1){1'b0}}, write_ok};
  assign commit_ok   = (state == IDLE) && pkt_commit && (count_after != '0);

  assign baud_tick    = (baud_cnt == BAUD_W'(BAUD_DIVISOR - 1));
  assign last_payload = ({1'b0, byte_idx} == (byte_count - CNT_W'(1)));
  assign gap_end      = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef UART_PKT_CHECKSUM_EN
  // The running sum covers every payload frame already finished. When the
  // last payload frame ends, the sum is complete at the same edge that
  // starts the checksum frame, so its data bits always see the final value.
  logic [7:0] csum_acc;
  logic       csum_phase;

  assign cur_byte   = csum_phase ? (8'd0 - csum_acc) : buffer[byte_idx];
  assign last_frame = csum_phase;
`else
  assign cur_byte   = buffer[byte_idx];
  assign last_frame = last_payload;
`endif

  assign busy        = (state != IDLE);
  assign buffer_full = (byte_count == CNT_W'(MAX_LEN));
  assign pkt_sent    = (state == GAP) && gap_end;
  assign uart_tx_pin = tx_reg;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next line level. The line level is registered, so the
  // value chosen here appears on the pin one cycle later. That is why the
  // start bit is chosen in the commit cycle, and why each bit's successor
  // is chosen on the last cycle of the current bit.
  always_comb begin
    state_next = state;
    tx_next    = tx_reg;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (commit_ok) begin
          state_next = SEND;
          tx_next    = 1'b0;
        end
      end
      SEND: begin
        if (baud_tick) begin
          if (bit_idx == 4'd9) begin
            if (last_frame) begin
              state_next = GAP;
              tx_next    = 1'b1;
            end else begin
              tx_next = 1'b0;
            end
          end else if (bit_idx == 4'd8) begin
            tx_next = 1'b1;
          end else begin
            tx_next = cur_byte[bit_idx[2:0]];
          end
        end
      end
      GAP: begin
        tx_next = 1'b1;
        if (gap_end) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Serializer datapath: line register, bit timing, frame sequencing and
  // the idle-gap counter. bit_idx 0 is the start bit, 1..8 are d0..d7 and
  // 9 is the stop bit. A new frame starts on the same edge that ends the
  // previous stop bit, so frames sit back to back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_reg   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_acc   <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      tx_reg <= tx_next;
      case (state)
        IDLE: begin
          if (commit_ok) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_acc   <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
`ifdef UART_PKT_CHECKSUM_EN
              if (!csum_phase) begin
                csum_acc <= csum_acc + cur_byte;
                if (last_payload) begin
                  csum_phase <= 1'b1;
                end else begin
                  byte_idx <= byte_idx + IDX_W'(1);
                end
              end else begin
                gap_cnt <= '0;
              end
`else
              if (!last_payload) begin
                byte_idx <= byte_idx + IDX_W'(1);
              end else begin
                gap_cnt <= '0;
              end
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: begin
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Byte count and sticky overflow. Both clear together on the final gap
  // cycle. That clear takes priority over a dropped write in the same cycle,
  // so the next packet starts with a clean flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (pkt_sent) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (write_ok) begin
        byte_count <= count_after;
      end
      if (write_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Packet storage. It has no reset because byte_count controls which
  // entries are valid.
  always_ff @(posedge clock) begin
    if (write_ok) begin
      buffer[byte_count[IDX_W-1:0]] <= pkt_data_in;
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_packet_tx
//
// Scoreboard bench for uart_packet_tx with a divisor of 10, a 4-byte buffer
// and a 2-byte gap. The stimulus pushes the expected frames and packets
// into queues. A line monitor decodes the serial pin cycle by cycle, pops
// the queues and compares the results.
// ---------------------------------------------------------------------------
module tb_uart_packet_tx;

  localparam int CLK_HZ    = 1152000;
  localparam int BAUD      = 115200;
  localparam int MAXL      = 4;
  localparam int GAPB      = 2;
  localparam int DIV       = 10;
  localparam int FRAME_CYC = 10 * DIV;
  localparam int GAP_CYC   = GAPB * FRAME_CYC;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tx_pin;
  logic [7:0] pkt_data_in = 8'h00;
  logic       pkt_write_en = 1'b0;
  logic       pkt_commit = 1'b0;
  logic       busy;
  logic       buffer_full;
  logic [2:0] byte_count;
  logic       overflow;
  logic       pkt_sent;

  typedef struct {
    logic [7:0] data;
    bit         first;
  } frame_t;

  frame_t frame_q[$];
  int     pkt_q[$];

  int checks = 0;
  int errors = 0;

  uart_packet_tx #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD),
    .MAX_LEN(MAXL),
    .GAP_BYTES(GAPB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uart_tx_pin(uart_tx_pin),
    .pkt_data_in(pkt_data_in),
    .pkt_write_en(pkt_write_en),
    .pkt_commit(pkt_commit),
    .busy(busy),
    .buffer_full(buffer_full),
    .byte_count(byte_count),
    .overflow(overflow),
    .pkt_sent(pkt_sent)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Shared comparison helper. Every check goes through this task.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then drop the strobes 1 time unit after the edge.
  task automatic applyStimulus(input logic [7:0] data, input logic wr,
                               input logic cm);
    pkt_data_in  = data;
    pkt_write_en = wr;
    pkt_commit   = cm;
    @(posedge clock);
    #1;
    pkt_write_en = 1'b0;
    pkt_commit   = 1'b0;
  endtask

  // Record the frames and the packet that the next commit should produce.
  task automatic expectPacket(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int n);
    logic [7:0] bs [4];
    frame_t     f;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < n; i++) begin
      f.data  = bs[i];
      f.first = (i == 0);
      frame_q.push_back(f);
`ifdef UART_PKT_CHECKSUM_EN
      sum = sum + bs[i];
`endif
    end
`ifdef UART_PKT_CHECKSUM_EN
    f.data  = 8'h00 - sum;
    f.first = 1'b0;
    frame_q.push_back(f);
`endif
    pkt_q.push_back(n + EXTRA);
  endtask

  // Bounded wait for busy to drop. The first argument is the number of
  // cycles already spent since the commit edge.
  task automatic waitDone(input string name, input int start_cnt,
                          input int expect_cycles);
    int cnt;
    cnt = start_cnt;
    while (busy === 1'b1 && cnt < 4000) begin
      cnt++;
      @(posedge clock);
      #1;
    end
    checkOutput(name, cnt, expect_cycles);
  endtask

  // Line monitor and scoreboard.
  int         mon_cnt;
  int         idle_run;
  int         gap_before;
  int         bit_errs;
  int         pkt_frames;
  int         exp_n;
  bit         mon_active;
  bit         have_exp;
  bit         post_sent;
  logic [7:0] rx_byte;
  logic       exp_bit;
  frame_t     cur_exp;

  initial begin
    mon_active = 1'b0;
    post_sent  = 1'b0;
    idle_run   = 0;
    pkt_frames = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_active = 1'b0;
        post_sent  = 1'b0;
        idle_run   = 0;
        pkt_frames = 0;
      end else begin
        if (post_sent) begin
          post_sent = 1'b0;
          checkOutput("pkt_sent_single_pulse", pkt_sent, 1'b0);
          checkOutput("busy_after_sent", busy, 1'b0);
          checkOutput("count_after_sent", byte_count, 3'd0);
          checkOutput("overflow_after_sent", overflow, 1'b0);
        end
        if (!mon_active) begin
          if (uart_tx_pin === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            bit_errs   = 0;
            rx_byte    = 8'h00;
            gap_before = idle_run;
            have_exp   = (frame_q.size() != 0);
            if (have_exp) cur_exp = frame_q.pop_front();
          end else begin
            idle_run++;
          end
        end
        if (mon_active) begin
          if (mon_cnt < 10) begin
            exp_bit = 1'b0;
          end else if (mon_cnt >= 90) begin
            exp_bit = 1'b1;
          end else begin
            exp_bit = cur_exp.data[mon_cnt/10 - 1];
            if (mon_cnt % 10 == 5) rx_byte[mon_cnt/10 - 1] = uart_tx_pin;
          end
          if (have_exp && uart_tx_pin !== exp_bit) bit_errs++;
          if (mon_cnt == FRAME_CYC - 1) begin
            mon_active = 1'b0;
            idle_run   = 0;
            pkt_frames++;
            checkOutput("frame_expected", have_exp, 1'b1);
            if (have_exp) begin
              checkOutput("frame_data", rx_byte, cur_exp.data);
              checkOutput("frame_bit_timing", bit_errs, 0);
              if (!cur_exp.first) checkOutput("interframe_gap", gap_before, 0);
            end
          end else begin
            mon_cnt++;
          end
        end
        if (pkt_sent === 1'b1) begin
          checkOutput("pkt_sent_expected", pkt_q.size() != 0, 1'b1);
          exp_n = (pkt_q.size() != 0) ? pkt_q.pop_front() : -1;
          checkOutput("pkt_frame_count", pkt_frames, exp_n);
          checkOutput("gap_length", idle_run, GAP_CYC);
          pkt_frames = 0;
          post_sent  = 1'b1;
        end
      end
    end
  end

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int bad;

    // Outputs while reset is held.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_pin", uart_tx_pin, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_full", buffer_full, 1'b0);
    checkOutput("reset_count", byte_count, 3'd0);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_pkt_sent", pkt_sent, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Single byte 0xA5.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("single_count", byte_count, 3'd1);
    expectPacket(8'hA5, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("single_busy", busy, 1'b1);
    checkOutput("single_start_bit", uart_tx_pin, 1'b0);
    waitDone("single_duration", 0, (1 + EXTRA) * FRAME_CYC + GAP_CYC);
    repeat (3) @(posedge clock);
    #1;

    // Back-to-back 0x01 0x02 0x03, with a write and a commit during SEND.
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0);
    expectPacket(8'h01, 8'h02, 8'h03, 8'h00, 3);
    applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (50) @(posedge clock);
    #1;
    applyStimulus(8'h77, 1'b1, 1'b1);
    checkOutput("busy_write_overflow", overflow, 1'b1);
    checkOutput("busy_write_count", byte_count, 3'd3);
    waitDone("b2b_duration", 51, (3 + EXTRA) * FRAME_CYC + GAP_CYC);
    repeat (3) @(posedge clock);
    #1;

    // Fill to capacity plus one dropped byte.
    applyStimulus(8'h10, 1'b1, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    applyStimulus(8'h13, 1'b1, 1'b0);
    checkOutput("full_after_4", buffer_full, 1'b1);
    checkOutput("count_after_4", byte_count, 3'd4);
    checkOutput("no_overflow_at_4", overflow, 1'b0);
    applyStimulus(8'h14, 1'b1, 1'b0);
    checkOutput("overflow_after_5", overflow, 1'b1);
    checkOutput("count_after_5", byte_count, 3'd4);
    expectPacket(8'h10, 8'h11, 8'h12, 8'h13, 4);
    applyStimulus(8'h00, 1'b0, 1'b1);
    waitDone("full_duration", 0, (4 + EXTRA) * FRAME_CYC + GAP_CYC);
    repeat (3) @(posedge clock);
    #1;

    // Commit with an empty buffer: no activity.
    applyStimulus(8'h00, 1'b0, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || uart_tx_pin !== 1'b1) bad++;
      @(posedge clock);
      #1;
    end
    checkOutput("empty_commit_quiet", bad, 0);

    // Write and commit in the same cycle on an empty buffer.
    expectPacket(8'h3C, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(8'h3C, 1'b1, 1'b1);
    checkOutput("wc_busy", busy, 1'b1);
    checkOutput("wc_count", byte_count, 3'd1);
    waitDone("wc_duration", 0, (1 + EXTRA) * FRAME_CYC + GAP_CYC);
    repeat (3) @(posedge clock);
    #1;

    // Reset during d2 of the first frame (0x5A has d2 = 0).
    applyStimulus(8'h5A, 1'b1, 1'b0);
    applyStimulus(8'h6B, 1'b1, 1'b0);
    expectPacket(8'h5A, 8'h6B, 8'h00, 8'h00, 2);
    applyStimulus(8'h00, 1'b0, 1'b1);
    repeat (34) @(posedge clock);
    #1;
    checkOutput("pre_reset_pin_low", uart_tx_pin, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_pin", uart_tx_pin, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_count", byte_count, 3'd0);
    frame_q.delete();
    pkt_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    applyStimulus(8'hC3, 1'b1, 1'b0);
    expectPacket(8'hC3, 8'h00, 8'h00, 8'h00, 1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    waitDone("post_reset_duration", 0, (1 + EXTRA) * FRAME_CYC + GAP_CYC);
    repeat (5) @(posedge clock);
    #1;

`ifdef UART_PKT_CHECKSUM_EN
    // Checksum frame: 0x01, 0x02 -> 0xFD.
    applyStimulus(8'h01, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0);
    expectPacket(8'h01, 8'h02, 8'h00, 8'h00, 2);
    applyStimulus(8'h00, 1'b0, 1'b1);
    waitDone("csum_duration", 0, 3 * FRAME_CYC + GAP_CYC);
    repeat (5) @(posedge clock);
    #1;
`endif

    checkOutput("frames_left", frame_q.size(), 0);
    checkOutput("packets_left", pkt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
